id_ex_stage: RTL and testbench

Decode/execute pipeline boundary of the 19-bit pipelined CPU, sitting directly downstream of the register file. It does three things:
- resolves RAW hazards on the two register-file read operands by bypassing from EX, MEM and WB;
- detects load-use hazards, stalling decode and inserting a bubble;
- latches the resolved operands and control into the ID/EX pipeline register, honouring branch flush and downstream hold.

It also keeps a saturating bubble counter for performance debug.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes and control-bundle types for the 19-bit pipelined CPU.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

   localparam int DW  = 19;
   localparam int AW  = 3;
   localparam int PCW = 8;
   localparam int OPW = 5;

   localparam logic [OPW-1:0] ALU_ADD = 5'd0;
   localparam logic [OPW-1:0] ALU_SUB = 5'd1;
   localparam logic [OPW-1:0] ALU_AND = 5'd2;
   localparam logic [OPW-1:0] ALU_OR  = 5'd3;
   localparam logic [OPW-1:0] ALU_XOR = 5'd4;
   localparam logic [OPW-1:0] ALU_SLL = 5'd5;
   localparam logic [OPW-1:0] ALU_SRL = 5'd6;
   localparam logic [OPW-1:0] ALU_SLT = 5'd7;

   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memread;
      logic memwrite;
      logic push;
      logic pop;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Three-source priority bypass for one register-file operand: EX > MEM > WB > register file.
// Purely combinational, zero latency; hit qualification is done by the caller.
module fwd_mux #(
   parameter int DW = 19
) (
   input  logic          ex_hit,
   input  logic          mem_hit,
   input  logic          wb_hit,
   input  logic [DW-1:0] ex_data,
   input  logic [DW-1:0] mem_data,
   input  logic [DW-1:0] wb_data,
   input  logic [DW-1:0] rf_data,
   output logic [DW-1:0] operand
);

   always_comb begin
      operand = rf_data;
      if (ex_hit)
         operand = ex_data;
      else if (mem_hit)
         operand = mem_data;
      else if (wb_hit)
         operand = wb_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: operand bypass, load-use stall, pipeline register and bubble counter.
// One cycle ID->EX; flush beats hold, hold freezes the register, load-use inserts a bubble.
module id_ex_stage #(
   parameter int DW  = cpu_pkg::DW,
   parameter int AW  = cpu_pkg::AW,
   parameter int PCW = cpu_pkg::PCW,
   parameter int OPW = cpu_pkg::OPW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ID_valid,
   input  logic [PCW-1:0] ID_pc,
   input  logic [AW-1:0]  ID_rs1,
   input  logic [AW-1:0]  ID_rs2,
   input  logic [AW-1:0]  ID_ws,
   input  logic           ID_use_rs1,
   input  logic           ID_use_rs2,
   input  logic [DW-1:0]  ID_rd1,
   input  logic [DW-1:0]  ID_rd2,
   input  logic [DW-1:0]  ID_imm,
   input  logic [OPW-1:0] ID_aluop,
   input  logic           ID_regwrite,
   input  logic           ID_memread,
   input  logic           ID_memwrite,
   input  logic           ID_push,
   input  logic           ID_pop,
   input  logic [DW-1:0]  EX_result,
   input  logic [AW-1:0]  MEM_ws,
   input  logic           MEM_regwrite,
   input  logic [DW-1:0]  MEM_result,
   input  logic [AW-1:0]  WB_ws,
   input  logic           WB_regwrite,
   input  logic [DW-1:0]  wd,
   input  logic           EX_flush,
   input  logic           EX_hold,
   output logic           ID_stall,
   output logic           EX_valid,
   output logic           EX_regwrite,
   output logic           EX_memread,
   output logic           EX_memwrite,
   output logic           EX_push,
   output logic           EX_pop,
   output logic [PCW-1:0] EX_pc,
   output logic [AW-1:0]  EX_ws,
   output logic [OPW-1:0] EX_aluop,
   output logic [DW-1:0]  EX_op1,
   output logic [DW-1:0]  EX_op2,
   output logic [DW-1:0]  EX_imm,
   output logic [15:0]    bubble_count
);

   import cpu_pkg::ctrl_t;
   import cpu_pkg::CTRL_BUBBLE;

   ctrl_t         ex_ctrl;
   ctrl_t         id_ctrl;
   logic          ex_fwd_ok;
   logic          load_use;
   logic [DW-1:0] op1_fwd;
   logic [DW-1:0] op2_fwd;

   // A load in EX has no result yet, so it may only stall, never forward.
   assign ex_fwd_ok = ex_ctrl.valid & ex_ctrl.regwrite & ~ex_ctrl.memread;

   assign load_use = ID_valid & ex_ctrl.valid & ex_ctrl.memread &
                     ((ID_use_rs1 & (ex_ctrl_ws_eq(ID_rs1))) |
                      (ID_use_rs2 & (ex_ctrl_ws_eq(ID_rs2))));

   assign ID_stall = load_use | EX_hold;

   function automatic logic ex_ctrl_ws_eq(input logic [AW-1:0] rs);
      return EX_ws == rs;
   endfunction

   fwd_mux #(.DW(DW)) u_fwd_op1 (
      .ex_hit   (ex_fwd_ok & (EX_ws == ID_rs1)),
      .mem_hit  (MEM_regwrite & (MEM_ws == ID_rs1)),
      .wb_hit   (WB_regwrite & (WB_ws == ID_rs1)),
      .ex_data  (EX_result),
      .mem_data (MEM_result),
      .wb_data  (wd),
      .rf_data  (ID_rd1),
      .operand  (op1_fwd)
   );

   fwd_mux #(.DW(DW)) u_fwd_op2 (
      .ex_hit   (ex_fwd_ok & (EX_ws == ID_rs2)),
      .mem_hit  (MEM_regwrite & (MEM_ws == ID_rs2)),
      .wb_hit   (WB_regwrite & (WB_ws == ID_rs2)),
      .ex_data  (EX_result),
      .mem_data (MEM_result),
      .wb_data  (wd),
      .rf_data  (ID_rd2),
      .operand  (op2_fwd)
   );

   always_comb begin
      id_ctrl          = CTRL_BUBBLE;
      id_ctrl.valid    = ID_valid;
      id_ctrl.regwrite = ID_regwrite & ID_valid;
      id_ctrl.memread  = ID_memread & ID_valid;
      id_ctrl.memwrite = ID_memwrite & ID_valid;
      id_ctrl.push     = ID_push & ID_valid;
      id_ctrl.pop      = ID_pop & ID_valid;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl      <= CTRL_BUBBLE;
         EX_pc        <= '0;
         EX_ws        <= '0;
         EX_aluop     <= '0;
         EX_op1       <= '0;
         EX_op2       <= '0;
         EX_imm       <= '0;
         bubble_count <= '0;
      end else if (EX_flush || (!EX_hold && load_use)) begin
         ex_ctrl  <= CTRL_BUBBLE;
         EX_pc    <= '0;
         EX_ws    <= '0;
         EX_aluop <= '0;
         EX_op1   <= '0;
         EX_op2   <= '0;
         EX_imm   <= '0;
         // Only load-use bubbles are a performance event; flushes are not counted.
         if (!EX_flush && bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
      end else if (!EX_hold) begin
         ex_ctrl  <= id_ctrl;
         EX_pc    <= ID_pc;
         EX_ws    <= ID_ws;
         EX_aluop <= ID_aluop;
         EX_op1   <= op1_fwd;
         EX_op2   <= op2_fwd;
         EX_imm   <= ID_imm;
      end
   end

   assign EX_valid    = ex_ctrl.valid;
   assign EX_regwrite = ex_ctrl.regwrite;
   assign EX_memread  = ex_ctrl.memread;
   assign EX_memwrite = ex_ctrl.memwrite;
   assign EX_push     = ex_ctrl.push;
   assign EX_pop      = ex_ctrl.pop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases then random traffic against a rule-level model.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid, regwrite, memread, memwrite, push, pop;
      logic [7:0]  pc;
      logic [2:0]  ws;
      logic [4:0]  aluop;
      logic [18:0] op1, op2, imm;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic ID_valid, ID_use_rs1, ID_use_rs2, ID_regwrite, ID_memread, ID_memwrite, ID_push, ID_pop;
   logic [7:0]  ID_pc;
   logic [2:0]  ID_rs1, ID_rs2, ID_ws, MEM_ws, WB_ws;
   logic [18:0] ID_rd1, ID_rd2, ID_imm, EX_result, MEM_result, wd;
   logic [4:0]  ID_aluop;
   logic MEM_regwrite, WB_regwrite, EX_flush, EX_hold;
   logic ID_stall, EX_valid, EX_regwrite, EX_memread, EX_memwrite, EX_push, EX_pop;
   logic [7:0]  EX_pc;
   logic [2:0]  EX_ws;
   logic [4:0]  EX_aluop;
   logic [18:0] EX_op1, EX_op2, EX_imm;
   logic [15:0] bubble_count;

   int   total = 0;
   int   bad = 0;
   exp_t m;
   exp_t expq[$];
   logic last_stall = 1'b0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_ws(ID_ws), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
      .ID_imm(ID_imm), .ID_aluop(ID_aluop), .ID_regwrite(ID_regwrite), .ID_memread(ID_memread),
      .ID_memwrite(ID_memwrite), .ID_push(ID_push), .ID_pop(ID_pop), .EX_result(EX_result),
      .MEM_ws(MEM_ws), .MEM_regwrite(MEM_regwrite), .MEM_result(MEM_result), .WB_ws(WB_ws),
      .WB_regwrite(WB_regwrite), .wd(wd), .EX_flush(EX_flush), .EX_hold(EX_hold), .ID_stall(ID_stall),
      .EX_valid(EX_valid), .EX_regwrite(EX_regwrite), .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
      .EX_push(EX_push), .EX_pop(EX_pop), .EX_pc(EX_pc), .EX_ws(EX_ws), .EX_aluop(EX_aluop),
      .EX_op1(EX_op1), .EX_op2(EX_op2), .EX_imm(EX_imm), .bubble_count(bubble_count)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Newest producer wins: the EX instruction (if it is not a load), then MEM, then WB, else the file.
   function automatic logic [18:0] resolve(input logic [2:0] rs, input logic [18:0] rd);
      if (m.valid && m.regwrite && !m.memread && m.ws == rs) return EX_result;
      if (MEM_regwrite && MEM_ws == rs) return MEM_result;
      if (WB_regwrite && WB_ws == rs) return wd;
      return rd;
   endfunction

   task automatic step();
      logic lu;
      exp_t n;
      #1;
      lu = ID_valid && m.valid && m.memread &&
           ((ID_use_rs1 && m.ws == ID_rs1) || (ID_use_rs2 && m.ws == ID_rs2));
      last_stall = lu;
      chk("id_stall", ID_stall, lu || EX_hold);
      n = m;
      if (EX_flush) begin
         n = '0;
         n.cnt = m.cnt;
      end else if (EX_hold) begin
         n = m;
      end else if (lu) begin
         n = '0;
         n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
      end else begin
         n.valid    = ID_valid;
         n.regwrite = ID_regwrite && ID_valid;
         n.memread  = ID_memread && ID_valid;
         n.memwrite = ID_memwrite && ID_valid;
         n.push     = ID_push && ID_valid;
         n.pop      = ID_pop && ID_valid;
         n.pc       = ID_pc;
         n.ws       = ID_ws;
         n.aluop    = ID_aluop;
         n.op1      = resolve(ID_rs1, ID_rd1);
         n.op2      = resolve(ID_rs2, ID_rd2);
         n.imm      = ID_imm;
      end
      m = n;
      expq.push_back(n);
   endtask

   task automatic idle();
      {ID_valid, ID_use_rs1, ID_use_rs2, ID_regwrite, ID_memread, ID_memwrite, ID_push, ID_pop} = '0;
      {ID_pc, ID_rs1, ID_rs2, ID_ws, ID_rd1, ID_rd2, ID_imm, ID_aluop} = '0;
      {EX_result, MEM_ws, MEM_regwrite, MEM_result, WB_ws, WB_regwrite, wd, EX_flush, EX_hold} = '0;
   endtask

   task automatic rand_id();
      ID_valid    = ($urandom % 4) != 0;
      ID_pc       = 8'($urandom);
      ID_rs1      = 3'($urandom_range(0, 3));
      ID_rs2      = 3'($urandom_range(0, 3));
      ID_ws       = 3'($urandom_range(0, 3));
      ID_use_rs1  = 1'($urandom);
      ID_use_rs2  = 1'($urandom);
      ID_rd1      = 19'($urandom);
      ID_rd2      = 19'($urandom);
      ID_imm      = 19'($urandom);
      ID_aluop    = 5'($urandom);
      ID_regwrite = 1'($urandom);
      ID_memread  = ($urandom % 3) == 0;
      ID_memwrite = 1'($urandom);
      ID_push     = 1'($urandom);
      ID_pop      = 1'($urandom);
   endtask

   task automatic rand_env();
      EX_result    = 19'($urandom);
      MEM_ws       = 3'($urandom_range(0, 3));
      MEM_regwrite = 1'($urandom);
      MEM_result   = 19'($urandom);
      WB_ws        = 3'($urandom_range(0, 3));
      WB_regwrite  = 1'($urandom);
      wd           = 19'($urandom);
      EX_flush     = ($urandom % 16) == 0;
      EX_hold      = ($urandom % 8) == 0;
   endtask

   initial begin : monitor
      exp_t e;
      exp_t act;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() != 0) begin
            e = expq.pop_front();
            act = {EX_valid, EX_regwrite, EX_memread, EX_memwrite, EX_push, EX_pop, EX_pc, EX_ws,
                   EX_aluop, EX_op1, EX_op2, EX_imm, bubble_count};
            total++;
            if (act !== e) begin
               bad++;
               $display("FAIL ex_regs got=%h want=%h", act, e);
            end
         end
      end
   end

   initial begin : driver
      idle();
      reset = 1'b1;
      m = '0;
      #1;
      chk("reset_valid", EX_valid, 1'b0);
      chk("reset_count", bubble_count, 16'd0);
      @(negedge clk);
      reset = 1'b0;

      // WB bypass covers the same-cycle register-file write
      @(negedge clk);
      idle();
      WB_regwrite = 1'b1; WB_ws = 3'd3; wd = 19'h12345;
      ID_valid = 1'b1; ID_rs1 = 3'd3; ID_use_rs1 = 1'b1; ID_rd1 = '0;
      step();
      @(posedge clk); #1;
      chk("wb_bypass", EX_op1, 19'h12345);

      // Priority: EX over MEM over WB
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_regwrite = 1'b1; ID_ws = 3'd2;
      step();
      @(negedge clk);
      idle();
      EX_result = 19'd5; MEM_regwrite = 1'b1; MEM_ws = 3'd2; MEM_result = 19'd6;
      WB_regwrite = 1'b1; WB_ws = 3'd2; wd = 19'd7;
      ID_valid = 1'b1; ID_rs2 = 3'd2; ID_use_rs2 = 1'b1; ID_regwrite = 1'b1; ID_ws = 3'd1;
      step();
      @(posedge clk); #1;
      chk("prio_ex", EX_op2, 19'd5);
      @(negedge clk);
      step();
      @(posedge clk); #1;
      chk("prio_mem", EX_op2, 19'd6);

      // Load-use: one-cycle stall, one counted bubble, then MEM forwarding
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_memread = 1'b1; ID_regwrite = 1'b1; ID_ws = 3'd4;
      step();
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_use_rs1 = 1'b1; ID_rs1 = 3'd4; ID_rd1 = 19'd1;
      step();
      chk("lu_stall", ID_stall, 1'b1);
      @(posedge clk); #1;
      chk("lu_bubble", EX_valid, 1'b0);
      chk("lu_count", bubble_count, 16'd1);
      @(negedge clk);
      MEM_regwrite = 1'b1; MEM_ws = 3'd4; MEM_result = 19'd9;
      step();
      chk("lu_one_cycle", ID_stall, 1'b0);
      @(posedge clk); #1;
      chk("lu_mem_fwd", EX_op1, 19'd9);

      // Flush beats hold and is not counted; hold alone freezes
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_regwrite = 1'b1; ID_ws = 3'd5; EX_flush = 1'b1; EX_hold = 1'b1;
      step();
      @(posedge clk); #1;
      chk("flush_valid", EX_valid, 1'b0);
      chk("flush_count", bubble_count, 16'd1);
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_pc = 8'h5A; ID_regwrite = 1'b1; ID_ws = 3'd6; ID_imm = 19'h7ABC;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rand_id();
         EX_hold = 1'b1;
         step();
         @(posedge clk); #1;
         chk("hold_pc", EX_pc, 8'h5A);
         chk("hold_imm", EX_imm, 19'h7ABC);
      end

      // Saturation: preload near the top, then keep stalling
      @(negedge clk);
      idle();
      force dut.bubble_count = 16'hFFFD;
      #1;
      release dut.bubble_count;
      m.cnt = 16'hFFFD;
      ID_valid = 1'b1; ID_memread = 1'b1; ID_regwrite = 1'b1; ID_ws = 3'd4;
      ID_use_rs1 = 1'b1; ID_rs1 = 3'd4;
      step();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         step();
      end
      @(posedge clk); #1;
      chk("sat_count", bubble_count, 16'hFFFF);

      last_stall = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!last_stall) rand_id();
         rand_env();
         step();
      end

      // Asynchronous reset mid-stream with a valid instruction in EX
      @(negedge clk);
      idle();
      ID_valid = 1'b1; ID_pc = 8'h33; ID_imm = 19'h1;
      step();
      @(negedge clk);
      chk("pre_rst_valid", EX_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk("rst_valid", EX_valid, 1'b0);
      chk("rst_pc", EX_pc, 8'h0);
      chk("rst_imm", EX_imm, 19'h0);
      chk("rst_count", bubble_count, 16'd0);
      m = '0;
      @(negedge clk);
      reset = 1'b0;
      last_stall = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!last_stall) rand_id();
         rand_env();
         step();
      end

      @(negedge clk);
      idle();
      #20;
      chk("queue_drained", 64'(expq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
